mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data word width; ADDR_WIDTH, default 8, byte-address width.
REQ-002 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  CPU access request; sampled only in IDLE.
REQ-005 i_wr  input  1  1 = store, 0 = load.
REQ-006 i_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 i_signed  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-008 i_addr  input  ADDR_WIDTH  byte address.
REQ-009 i_wdata  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 o_busy  output  1  high whenever state != IDLE.
REQ-011 o_done  output  1  one-cycle completion pulse.
REQ-012 o_misalign  output  1  high with o_done when the request was rejected.
REQ-013 o_rdata  output  DATA_WIDTH  formatted load result.
REQ-014 o_ram_addr  output  ADDR_WIDTH  word-aligned byte address to RAM: {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-015 o_ram_data  output  DATA_WIDTH  RAM write data.
REQ-016 o_ram_we  output  1  RAM write enable.
REQ-017 i_ram_data  input  DATA_WIDTH  RAM read data, valid the cycle after the address is presented (registered read).

Function
REQ-018 FSM states SHALL be IDLE, RD, MRG, WR, DONE.
REQ-019 In IDLE with i_req=1, i_wr, i_size, i_signed, i_addr and i_wdata SHALL be latched; later input changes are ignored.
REQ-020 Misaligned or illegal requests SHALL go from IDLE to DONE with o_misalign=1 and no RAM access: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 Word store: IDLE->WR->DONE; o_done in cycle 2 after acceptance.
REQ-022 Load: IDLE->RD->MRG->DONE; o_done in cycle 3; o_rdata updated at the MRG->DONE edge.
REQ-023 Sub-word store: IDLE->RD->MRG->WR->DONE (read-modify-write); o_done in cycle 4.
REQ-024 Byte lanes SHALL be little-endian: byte lane = addr[1:0], bits [8*k+7:8*k]; half lane = addr[1], bits [16*h+15:16*h].
REQ-025 In MRG, the merged store word SHALL be registered with only the addressed lane(s) replaced by i_wdata and other lanes kept from i_ram_data.
REQ-026 o_ram_we SHALL be high only in WR, decoded from the state register; o_ram_addr SHALL be stable from RD or WR through the end of the access.
REQ-027 o_rdata SHALL hold its value until the next successful load completes; stores and misaligned requests leave it unchanged.
REQ-028 DONE SHALL always return to IDLE; i_req during any non-IDLE state, DONE included, SHALL be ignored and not queued.

Reset
REQ-029 On i_rst=1 at an edge: state=IDLE; o_rdata, o_ram_addr and o_ram_data=0; o_done, o_misalign and o_busy=0 from the next cycle.
REQ-030 Reset mid-operation SHALL abort without o_done; a WR cycle coincident with the reset edge still writes, because the RAM has no reset.

Structure
REQ-031 Shared package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-032 A combinational sub-module mem_lane_fmt SHALL perform load extract/extend and store lane merge; the FSM and registers stay in mem_ctrl.

Verification
REQ-033 RAM byte 0x20 preloaded with word 0x8899AABB; word load from 0x20 -> o_done in cycle 3, o_rdata=0x8899AABB, o_misalign=0.
REQ-034 Byte load from 0x23: i_signed=1 -> 0xFFFFFF88; i_signed=0 -> 0x00000088.
REQ-035 Half store of 0x1234 to 0x22 -> o_ram_we high in cycle 3 with o_ram_data=0x1234AABB, o_done in cycle 4; a following word load from 0x20 returns 0x1234AABB.
REQ-036 Word store to 0x26 -> o_done and o_misalign in cycle 1; o_ram_we never high; RAM unchanged.
REQ-037 i_rst asserted during RD of a load -> o_busy=0 next cycle, no o_done, o_rdata=0.
REQ-038 i_req held high across two loads -> second accepted only in the cycle after DONE; two o_done pulses four cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the load/store memory controller
//
// Contents:
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL : i_size encodings
//   state_t                        : controller FSM state encoding
//   is_misaligned()                : request rejection rule
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Rejected requests: illegal size, odd half, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lane[0]) ||
           ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - combinational load extract/extend and store lane merge
//
// Ports:
//   size       in  access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   sign_ext   in  1 = sign-extend sub-word loads
//   lane       in  addr[1:0] of the access (little-endian byte lane)
//   wdata      in  right-aligned store data
//   ram_data   in  word read from RAM
//   load_data  out formatted load result
//   merge_data out ram_data with the addressed lane(s) replaced by wdata
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [1:0]            lane,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_data
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] lane_mask;

  // Lane k lives at bits [8k+7:8k]; a half is always at an even lane, so the
  // same byte shift covers both sub-word sizes.
  assign shamt   = {lane, 3'b000};
  assign shifted = ram_data >> shamt;

  always_comb begin
    load_data = ram_data;
    lane_mask = '1;
    case (size)
      SZ_BYTE: begin
        load_data = sign_ext ? {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]}
                             : {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
        lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << shamt;
      end
      SZ_HALF: begin
        load_data = sign_ext ? {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]}
                             : {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
        lane_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
      end
      default: ;
    endcase
  end

  assign merge_data = (ram_data & ~lane_mask) | ((wdata << shamt) & lane_mask);

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - CPU load/store front end to a word-wide registered-read RAM
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req/i_wr/i_size/i_signed/i_addr/i_wdata  CPU request, sampled in IDLE
//   o_busy              high whenever the FSM is not in IDLE
//   o_done, o_misalign  one-cycle completion pulse / rejected-request flag
//   o_rdata             last successful load result
//   o_ram_addr/o_ram_data/o_ram_we  RAM address (word aligned), write data, write enable
//   i_ram_data          RAM read data, one cycle after the address
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_misalign,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  state_t                state;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  mem_lane_fmt #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
    .size      (size_q),
    .sign_ext  (signed_q),
    .lane      (lane_q),
    .wdata     (wdata_q),
    .ram_data  (i_ram_data),
    .load_data (load_data),
    .merge_data(merge_data)
  );

  assign o_busy   = (state != IDLE);
  assign o_ram_we = (state == WR);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_done     <= 1'b0;
      o_misalign <= 1'b0;
      o_rdata    <= '0;
      o_ram_addr <= '0;
      o_ram_data <= '0;
      wr_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done     <= 1'b0;
          o_misalign <= 1'b0;
          if (i_req) begin
            wr_q     <= i_wr;
            size_q   <= i_size;
            signed_q <= i_signed;
            lane_q   <= i_addr[1:0];
            wdata_q  <= i_wdata;
            if (is_misaligned(i_size, i_addr[1:0])) begin
              // Rejected: RAM address and data are left untouched.
              state      <= DONE;
              o_done     <= 1'b1;
              o_misalign <= 1'b1;
            end else begin
              o_ram_addr <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
              if (i_wr && (i_size == SZ_WORD)) begin
                // Full-word store needs no read; data goes straight out.
                o_ram_data <= i_wdata;
                state      <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= MRG;
        MRG: begin
          // i_ram_data now holds the word addressed during RD.
          if (wr_q) begin
            o_ram_data <= merge_data;
            state      <= WR;
          end else begin
            o_rdata <= load_data;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        WR: begin
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          o_done     <= 1'b0;
          o_misalign <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
